// File: rtl/led_trail_pwm.sv
// led_trail_pwm: turns an N-bit on/off LED pattern into PWM-driven LEDs with a
// linear afterglow. Build macro LED_ACTIVE_LOW_EN inverts led_out (idle = all ones).
module led_trail_pwm #(
   parameter int N         = 8,
   parameter int W         = 4,
   parameter int DECAY_DIV = 20000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] pattern_in,
   output logic [N-1:0] led_out,
   output logic         busy
);

   localparam logic [W-1:0]  MAX        = {W{1'b1}};
   localparam logic [W-1:0]  PWM_LAST   = MAX - 1'b1;
   localparam int            PW         = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_DIV - 1);

`ifdef LED_ACTIVE_LOW_EN
   localparam logic [N-1:0] LED_POL = {N{1'b1}};
`else
   localparam logic [N-1:0] LED_POL = {N{1'b0}};
`endif

   logic [N-1:0]  sync1;
   logic [N-1:0]  sync2;
   logic [W-1:0]  pwm_cnt;
   logic [PW-1:0] presc;
   logic          decay_tick;
   logic [W-1:0]  bright [N];
   logic [N-1:0]  lit;
   logic          any_bright;

   // pattern_in is asynchronous to clk: two flops per bit before any use.
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pattern_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                      pwm_cnt <= '0;
      else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
      else                          pwm_cnt <= pwm_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                      presc <= '0;
      else if (presc == PRESC_LAST) presc <= '0;
      else                          presc <= presc + 1'b1;
   end

   assign decay_tick = (presc == PRESC_LAST);

   // Reload has priority over decay; decay saturates at zero.
   // NOTE: the brightness array is small register state, so it is reset explicitly with a loop.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) bright[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sync2[i])
               bright[i] <= MAX;
            else if (decay_tick && (bright[i] != '0))
               bright[i] <= bright[i] - 1'b1;
         end
      end
   end

   // NOTE: every always_comb output gets a default first, so no latch can be inferred.
   always_comb begin
      lit        = '0;
      any_bright = 1'b0;
      for (int i = 0; i < N; i++) begin
         lit[i]     = (pwm_cnt < bright[i]);
         any_bright = any_bright | (bright[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_out <= LED_POL;
         busy    <= 1'b0;
      end else begin
         led_out <= lit ^ LED_POL;
         busy    <= any_bright;
      end
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm: directed scenarios plus random patterns,
// all compared against a cycle-count based behavioural model.
`timescale 1ns/1ps
module tb_led_trail_pwm;

   localparam int N    = 8;
   localparam int W    = 4;
   localparam int DIV  = 4;
   localparam int MAXB = (1 << W) - 1;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic [N-1:0] POL = {N{1'b1}};
`else
   localparam logic [N-1:0] POL = {N{1'b0}};
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pattern_in;
   logic [N-1:0] led_out;
   logic         busy;

   led_trail_pwm #(.N(N), .W(W), .DECAY_DIV(DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .pattern_in (pattern_in),
      .led_out    (led_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Model: brightness per LED, pattern seen two edges late, and phases derived
   // from the number of edges since reset release.
   int           m_bright [N];
   logic [N-1:0] m_s1, m_s2;
   int           m_n;
   logic [N-1:0] m_led;
   logic         m_busy;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < N; i++) m_bright[i] = 0;
         m_s1 = '0; m_s2 = '0; m_n = 0;
         m_led = POL; m_busy = 1'b0;
      end else begin
         logic tick;
         tick   = ((m_n % DIV) == DIV - 1);
         m_led  = '0;
         m_busy = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_led[i] = ((m_n % MAXB) < m_bright[i]);
            if (m_bright[i] != 0) m_busy = 1'b1;
         end
         m_led = m_led ^ POL;
         for (int i = 0; i < N; i++) begin
            if (m_s2[i])                     m_bright[i] = MAXB;
            else if (tick && m_bright[i] > 0) m_bright[i] = m_bright[i] - 1;
         end
         m_s2 = m_s1;
         m_s1 = pattern_in;
         m_n++;
      end
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check({tag, " led"}, 32'(led_out), 32'(m_led));
      check({tag, " busy"}, 32'(busy), 32'(m_busy));
   endtask

   initial begin
      rst        = 1'b1;
      pattern_in = 8'hFF;
      m_s1 = '0; m_s2 = '0; m_n = 0; m_led = POL; m_busy = 1'b0;
      for (int i = 0; i < N; i++) m_bright[i] = 0;

      // Reset held with all pattern bits high
      for (int k = 0; k < 3; k++) begin
         cycle("reset");
         check("reset led const", 32'(led_out), 32'(POL));
         check("reset busy const", 32'(busy), 32'd0);
      end

      // Single LED lights on the 4th edge after release
      rst        = 1'b0;
      pattern_in = 8'h01;
      for (int k = 1; k <= 10; k++) begin
         cycle("light");
         if (k == 3) check("light pre-latency", 32'(led_out), 32'(POL));
         if (k >= 4) begin
            check("light solid", 32'(led_out), 32'(8'h01 ^ POL));
            check("light busy", 32'(busy), 32'd1);
         end
      end

      // Full fade of LED 0, then quiet
      pattern_in = 8'h00;
      for (int k = 0; k < 2 + MAXB * DIV + 20; k++) cycle("fade");
      check("fade done led", 32'(led_out), 32'(POL));
      check("fade done busy", 32'(busy), 32'd0);

      // LED 7 partially faded, then reloaded exactly on a decay-tick cycle
      pattern_in = 8'h80;
      for (int k = 0; k < 6; k++) cycle("pre-reload");
      pattern_in = 8'h00;
      for (int k = 0; k < 14; k++) cycle("pre-reload fade");
      for (int k = 0; k < DIV && ((m_n + 2) % DIV) != DIV - 1; k++) cycle("align");
      pattern_in = 8'h80;
      for (int k = 0; k < 40; k++) cycle("reload");
      check("reload solid", 32'(led_out), 32'(8'h80 ^ POL));

      // Reset in the middle of a fade
      pattern_in = 8'h01;
      for (int k = 0; k < 6; k++) cycle("midfade load");
      pattern_in = 8'h00;
      begin
         bit reached = 1'b0;
         for (int k = 0; k < 200 && !reached; k++) begin
            cycle("midfade wait");
            if (m_bright[0] == 7) reached = 1'b1;
         end
         check("midfade reached", 32'(reached), 32'd1);
      end
      rst = 1'b1;
      cycle("midfade rst");
      check("midfade rst led", 32'(led_out), 32'(POL));
      check("midfade rst busy", 32'(busy), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 80; k++) cycle("after rst");
      check("after rst busy", 32'(busy), 32'd0);

      // Random patterns with occasional reset pulses
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(7) == 0) begin
            if ($urandom_range(1) == 0) pattern_in = 8'(1 << $urandom_range(N - 1));
            else                        pattern_in = 8'($urandom_range(255));
         end else if ($urandom_range(15) == 0) begin
            pattern_in = 8'h00;
         end
         rst = ($urandom_range(299) == 0);
         cycle("random");
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
